// File: rtl/ps2_kbd_pkg.sv
// Shared constants, state encoding and event layout for the PS/2 set-2 keyboard decoder.
package ps2_kbd_pkg;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_E1     = 8'hE1;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam int unsigned EV_CODE_W   = 8;
  localparam int unsigned EV_MAKE_BIT = 8;
  localparam int unsigned EV_EXT_BIT  = 9;
  localparam int unsigned EV_W        = 10;

  localparam int unsigned MODS_W     = 7;
  localparam int unsigned MOD_LSHIFT = 0;
  localparam int unsigned MOD_RSHIFT = 1;
  localparam int unsigned MOD_LCTRL  = 2;
  localparam int unsigned MOD_RCTRL  = 3;
  localparam int unsigned MOD_LALT   = 4;
  localparam int unsigned MOD_RALT   = 5;
  localparam int unsigned MOD_CAPS   = 6;

  // Pause is E1 followed by seven more bytes that carry no extra information.
  localparam int unsigned         SKIP_W     = 3;
  localparam logic [SKIP_W-1:0]   PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE,
    ST_WAIT
  } kbd_state_e;

  typedef struct packed {
    logic                 ext;
    logic                 make;
    logic [EV_CODE_W-1:0] code;
  } kbd_event_t;

  function automatic logic [EV_W-1:0] pack_event(input kbd_event_t e);
    logic [EV_W-1:0] v;
    v                  = '0;
    v[EV_CODE_W-1:0]   = e.code;
    v[EV_MAKE_BIT]     = e.make;
    v[EV_EXT_BIT]      = e.ext;
    return v;
  endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// DEPTH x W synchronous FIFO holding decoded key events; DEPTH must be a power of 2.
module kbd_event_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  // Storage is cleared on reset so the head reads as zero while empty after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_decoder.sv
// PS/2 set-2 scancode decoder: prefix FSM, modifier/caps tracking, timeout and event queue.
// Optional typematic repeat filter enabled by defining KBD_REPEAT_FILTER_EN.
module ps2_kbd_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_ready,
  input  logic                   rx_overflow,
  input  logic [7:0]             rx_data,
  output logic                   rx_next,
  output logic                   rx_clear,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [EV_W-1:0]        ev_data,
  output logic [$clog2(DEPTH):0] ev_count,
  output logic [MODS_W-1:0]      mods,
  output logic                   err
);

  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  kbd_state_e          state_q, state_d;
  kbd_state_e          pend_q, pend_d;
  logic [SKIP_W-1:0]   skip_q, skip_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [MODS_W-1:0]   mods_q, mods_d;
  logic                caps_held_q, caps_held_d;
  logic                rx_next_q, rx_next_d;
  logic                rx_clear_q, rx_clear_d;
  logic                err_q, err_d;

`ifdef KBD_REPEAT_FILTER_EN
  logic                lm_valid_q, lm_valid_d;
  logic [8:0]          lm_key_q, lm_key_d;
`endif

  logic                consume_c;
  logic                complete_c;
  logic                push_c;
  kbd_event_t          key_c;
  logic                fifo_full;
  logic                fifo_empty;

  assign consume_c = (state_q != ST_WAIT) && rx_ready && !fifo_full;

  // Next-state, modifier and event generation.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    skip_d      = skip_q;
    tmo_d       = tmo_q;
    mods_d      = mods_q;
    caps_held_d = caps_held_q;
    rx_next_d   = 1'b0;
    rx_clear_d  = 1'b0;
    err_d       = 1'b0;
    complete_c  = 1'b0;
    push_c      = 1'b0;
    key_c       = '0;
`ifdef KBD_REPEAT_FILTER_EN
    lm_valid_d  = lm_valid_q;
    lm_key_d    = lm_key_q;
`endif

    if (rx_overflow) begin
      rx_clear_d = 1'b1;
      err_d      = 1'b1;
      state_d    = ST_IDLE;
      pend_d     = ST_IDLE;
      skip_d     = '0;
      tmo_d      = '0;
`ifdef KBD_REPEAT_FILTER_EN
      lm_valid_d = 1'b0;
`endif
    end else if (state_q == ST_WAIT) begin
      state_d = pend_q;
    end else if (consume_c) begin
      rx_next_d = 1'b1;
      state_d   = ST_WAIT;
      pend_d    = ST_IDLE;
      tmo_d     = '0;
      case (state_q)
        ST_IDLE: begin
          if (rx_data == SC_E0) begin
            pend_d = ST_EXT;
          end else if (rx_data == SC_F0) begin
            pend_d = ST_BRK;
          end else if (rx_data == SC_E1) begin
            pend_d = ST_PAUSE;
            skip_d = PAUSE_SKIP;
          end else begin
            complete_c = 1'b1;
          end
        end
        ST_EXT: begin
          if (rx_data == SC_F0) begin
            pend_d = ST_EXT_BRK;
          end else if (rx_data == SC_E0 || rx_data == SC_E1) begin
            err_d = 1'b1;
          end else begin
            complete_c = 1'b1;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          if (rx_data == SC_E0 || rx_data == SC_F0 || rx_data == SC_E1) begin
            err_d = 1'b1;
          end else begin
            complete_c = 1'b1;
          end
        end
        ST_PAUSE: begin
          skip_d = skip_q - SKIP_W'(1);
          if (skip_q == SKIP_W'(1)) begin
            key_c.ext  = 1'b1;
            key_c.make = 1'b1;
            key_c.code = SC_E1;
            push_c     = 1'b1;
          end else begin
            pend_d = ST_PAUSE;
          end
        end
        default: ;
      endcase
    end else if (TIMEOUT_CYC != 0 &&
                 (state_q == ST_EXT || state_q == ST_BRK ||
                  state_q == ST_EXT_BRK || state_q == ST_PAUSE)) begin
      tmo_d = tmo_q + TMO_W'(1);
      if (tmo_d == TMO_W'(TIMEOUT_CYC)) begin
        state_d = ST_IDLE;
        pend_d  = ST_IDLE;
        skip_d  = '0;
        tmo_d   = '0;
        err_d   = 1'b1;
      end
    end

    if (complete_c) begin
      key_c.ext  = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
      key_c.make = (state_q == ST_IDLE) || (state_q == ST_EXT);
      key_c.code = rx_data;
      push_c     = 1'b1;

      if (!key_c.ext) begin
        case (key_c.code)
          SC_LSHIFT: mods_d[MOD_LSHIFT] = key_c.make;
          SC_RSHIFT: mods_d[MOD_RSHIFT] = key_c.make;
          SC_CTRL:   mods_d[MOD_LCTRL]  = key_c.make;
          SC_ALT:    mods_d[MOD_LALT]   = key_c.make;
          SC_CAPS: begin
            // Only the first make of a press toggles; typematic repeats see caps_held set.
            if (key_c.make) begin
              if (!caps_held_q) begin
                mods_d[MOD_CAPS] = ~mods_q[MOD_CAPS];
              end
              caps_held_d = 1'b1;
            end else begin
              caps_held_d = 1'b0;
            end
          end
          default: ;
        endcase
      end else begin
        case (key_c.code)
          SC_CTRL: mods_d[MOD_RCTRL] = key_c.make;
          SC_ALT:  mods_d[MOD_RALT]  = key_c.make;
          default: ;
        endcase
      end

`ifdef KBD_REPEAT_FILTER_EN
      if (key_c.make) begin
        if (lm_valid_q && lm_key_q == {key_c.ext, key_c.code}) begin
          push_c = 1'b0;
        end else begin
          lm_valid_d = 1'b1;
          lm_key_d   = {key_c.ext, key_c.code};
        end
      end else if (lm_valid_q && lm_key_q == {key_c.ext, key_c.code}) begin
        lm_valid_d = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pend_q      <= ST_IDLE;
      skip_q      <= '0;
      tmo_q       <= '0;
      mods_q      <= '0;
      caps_held_q <= 1'b0;
      rx_next_q   <= 1'b0;
      rx_clear_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      skip_q      <= skip_d;
      tmo_q       <= tmo_d;
      mods_q      <= mods_d;
      caps_held_q <= caps_held_d;
      rx_next_q   <= rx_next_d;
      rx_clear_q  <= rx_clear_d;
      err_q       <= err_d;
    end
  end

`ifdef KBD_REPEAT_FILTER_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lm_valid_q <= 1'b0;
      lm_key_q   <= '0;
    end else begin
      lm_valid_q <= lm_valid_d;
      lm_key_q   <= lm_key_d;
    end
  end
`endif

  kbd_event_fifo #(
    .DEPTH (DEPTH),
    .W     (EV_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .data_i  (pack_event(key_c)),
    .pop_i   (ev_valid && ev_ready),
    .data_o  (ev_data),
    .count_o (ev_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign ev_valid = !fifo_empty;
  assign rx_next  = rx_next_q;
  assign rx_clear = rx_clear_q;
  assign err      = err_q;
  assign mods     = mods_q;

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Scoreboard bench for ps2_kbd_decoder: byte-queue receiver model, event monitor, directed scenarios.
module tb_ps2_kbd_decoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_ready = 1'b0;
  logic       rx_overflow = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_next;
  logic       rx_clear;
  logic       ev_valid;
  logic       ev_ready = 1'b0;
  logic [9:0] ev_data;
  logic [2:0] ev_count;
  logic [6:0] mods;
  logic       err;

  always #5 clk = ~clk;

  ps2_kbd_decoder #(
    .DEPTH       (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_ready    (rx_ready),
    .rx_overflow (rx_overflow),
    .rx_data     (rx_data),
    .rx_next     (rx_next),
    .rx_clear    (rx_clear),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_data     (ev_data),
    .ev_count    (ev_count),
    .mods        (mods),
    .err         (err)
  );

  logic [7:0] rx_q [$];
  logic [9:0] exp_q [$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int nxt_cnt = 0;
  int clr_cnt = 0;
  int err_cnt = 0;
  int last_nxt = -1000;
  int min_gap = 1000;
  bit hold = 1'b0;
  bit one_pop = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Receiver model plus event monitor, all on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rx_next) begin
      nxt_cnt++;
      if (cyc - last_nxt < min_gap) min_gap = cyc - last_nxt;
      last_nxt = cyc;
      if (rx_q.size() > 0) void'(rx_q.pop_front());
    end
    if (rx_clear) begin
      clr_cnt++;
      rx_q.delete();
    end
    if (err) err_cnt++;
    rx_ready = (rx_q.size() > 0);
    rx_data  = rx_ready ? rx_q[0] : 8'h00;

    ev_ready = !hold || one_pop;
    one_pop  = 1'b0;
    if (ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL event: got unexpected 0x%0h expected none", ev_data);
      end else begin
        chk("event", 32'(ev_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic send_seq(input logic [63:0] bytes, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      rx_q.push_back(bytes[8*i +: 8]);
    end
  endtask

  task automatic settle();
    int n = 0;
    while (rx_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (rx_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL rx_drain: got %0d bytes left expected 0", rx_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL ev_drain: got %0d events pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int e0;
    int c0;

    repeat (3) @(negedge clk);
    chk("rst_ev_valid", 32'(ev_valid), 0);
    chk("rst_ev_count", 32'(ev_count), 0);
    chk("rst_ev_data", 32'(ev_data), 0);
    chk("rst_mods", 32'(mods), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rx_next", 32'(rx_next), 0);
    chk("rst_rx_clear", 32'(rx_clear), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Plain make and break.
    n0 = nxt_cnt; e0 = err_cnt;
    exp_q.push_back(10'h11C);
    exp_q.push_back(10'h01C);
    send_seq(64'h1CF01C, 3);
    settle();
    drain();
    chk("basic_rx_next_pulses", 32'(nxt_cnt - n0), 3);
    chk("basic_err", 32'(err_cnt - e0), 0);

    // Extended and plain modifiers.
    exp_q.push_back(10'h314);
    send_seq(64'hE014, 2);
    settle();
    chk("mods_rctrl", 32'(mods), 32'(7'b0001000));
    exp_q.push_back(10'h112);
    send_seq(64'h12, 1);
    settle();
    chk("mods_lshift", 32'(mods), 32'(7'b0001001));
    exp_q.push_back(10'h214);
    send_seq(64'hE0F014, 3);
    settle();
    chk("mods_rctrl_rel", 32'(mods), 32'(7'b0000001));
    exp_q.push_back(10'h012);
    send_seq(64'hF012, 2);
    settle();
    drain();
    chk("mods_clear", 32'(mods), 0);

    // Caps Lock with typematic repeat.
    exp_q.push_back(10'h158);
    send_seq(64'h58, 1);
    settle();
    chk("caps_first", 32'(mods), 32'(7'b1000000));
`ifndef KBD_REPEAT_FILTER_EN
    exp_q.push_back(10'h158);
`endif
    send_seq(64'h58, 1);
    settle();
    chk("caps_repeat", 32'(mods), 32'(7'b1000000));
    exp_q.push_back(10'h058);
    send_seq(64'hF058, 2);
    settle();
    chk("caps_break", 32'(mods), 32'(7'b1000000));
    exp_q.push_back(10'h158);
    send_seq(64'h58, 1);
    settle();
    drain();
    chk("caps_second", 32'(mods), 0);

    // Pause sequence.
    e0 = err_cnt;
    exp_q.push_back(10'h3E1);
    send_seq(64'hE11477E1F014F077, 8);
    settle();
    drain();
    chk("pause_err", 32'(err_cnt - e0), 0);

    // Backpressure on a full queue.
    hold = 1'b1;
    repeat (2) @(negedge clk);
    n0 = nxt_cnt;
    exp_q.push_back(10'h11C);
    exp_q.push_back(10'h11B);
    exp_q.push_back(10'h123);
    exp_q.push_back(10'h12B);
    exp_q.push_back(10'h134);
    send_seq(64'h1C1B232B34, 5);
    repeat (24) @(negedge clk);
    chk("full_count", 32'(ev_count), 4);
    chk("full_rx_left", 32'(rx_q.size()), 1);
    chk("full_rx_next", 32'(nxt_cnt - n0), 4);
    one_pop = 1'b1;
    repeat (8) @(negedge clk);
    chk("refill_count", 32'(ev_count), 4);
    chk("refill_rx_left", 32'(rx_q.size()), 0);
    hold = 1'b0;
    drain();
    repeat (2) @(negedge clk);
    chk("empty_count", 32'(ev_count), 0);

    // Prefix timeout.
    e0 = err_cnt;
    send_seq(64'hF0, 1);
    settle();
    repeat (20) @(negedge clk);
    chk("tmo_err", 32'(err_cnt - e0), 1);
    exp_q.push_back(10'h11C);
    send_seq(64'h1C, 1);
    settle();
    drain();
    chk("tmo_err_once", 32'(err_cnt - e0), 1);

    // Overflow in the break state.
    exp_q.push_back(10'h112);
    send_seq(64'h12, 1);
    settle();
    drain();
    e0 = err_cnt; c0 = clr_cnt;
    send_seq(64'hF0, 1);
    settle();
    rx_overflow = 1'b1;
    @(negedge clk);
    rx_overflow = 1'b0;
    repeat (3) @(negedge clk);
    chk("ovf_clear", 32'(clr_cnt - c0), 1);
    chk("ovf_err", 32'(err_cnt - e0), 1);
    chk("ovf_mods_kept", 32'(mods), 32'(7'b0000001));
    exp_q.push_back(10'h11C);
    send_seq(64'h1C, 1);
    settle();
    drain();

    // Reset in mid-sequence.
    send_seq(64'hE0, 1);
    settle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_mods", 32'(mods), 0);
    chk("mid_rst_count", 32'(ev_count), 0);
    exp_q.push_back(10'h114);
    send_seq(64'h14, 1);
    settle();
    drain();
    chk("mid_rst_lctrl", 32'(mods), 32'(7'b0000100));

    chk("rx_next_gap", 32'(min_gap >= 2), 1);
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
